bitmap_sprite_gen: RTL and testbench

- Parametrised successor of the single-dot bitmap generator.
- Owns a 2^(X_BITS+Y_BITS)-entry video RAM (synchronous dual-port, one-cycle read latency) that holds N_DOTS independently bouncing dots.
- A control FSM schedules three kinds of RAM writes: power-up/user screen clear, per-frame erase/draw of each dot, and position loads.
- The read port is scanned by the VGA sync counters; output rgb is muxed with a configurable background colour.

---
 rtl/bitmap_sprite_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_bitmap_sprite_gen.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitmap_sprite_gen.sv
// rtl/bitmap_sprite_gen.sv - video RAM bitmap generator with N_DOTS bouncing dots
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high
//   video_on   display-active from the sync generator
//   pix_x      scan x (10 bits)
//   pix_y      scan y (10 bits)
//   load       single-cycle pulse, loads the next dot's position from pix_x/pix_y
//   clear      single-cycle pulse, requests a screen clear
//   trail_en   1 = leave the old dot position coloured
//   dot_color  draw colour of dot i at [i*COLOR_W +: COLOR_W]
//   busy       high while the control FSM is not idle
//   bit_rgb    pixel colour, one clock after pix_x/pix_y
module bitmap_sprite_gen #(
    parameter int X_BITS  = 7,
    parameter int Y_BITS  = 7,
    parameter int COLOR_W = 3,
    parameter int N_DOTS  = 2,
    parameter logic [COLOR_W-1:0] BG_RGB = 3'b110,
    parameter int REFR_Y  = 481
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        video_on,
    input  logic [9:0]                  pix_x,
    input  logic [9:0]                  pix_y,
    input  logic                        load,
    input  logic                        clear,
    input  logic                        trail_en,
    input  logic [N_DOTS*COLOR_W-1:0]   dot_color,
    output logic                        busy,
    output logic [COLOR_W-1:0]          bit_rgb
);

    localparam int A_W   = X_BITS + Y_BITS;
    localparam int IDX_W = (N_DOTS > 1) ? $clog2(N_DOTS) : 1;
    localparam logic [X_BITS-1:0] X_HI = X_BITS'((1 << X_BITS) - 2);
    localparam logic [Y_BITS-1:0] Y_HI = Y_BITS'((1 << Y_BITS) - 2);
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(N_DOTS - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_ERASE, S_DRAW} state_t;

    state_t               state;
    logic [X_BITS-1:0]    dot_x [N_DOTS];
    logic [Y_BITS-1:0]    dot_y [N_DOTS];
    logic [N_DOTS-1:0]    dir_x;              // 1 = moving +1
    logic [N_DOTS-1:0]    dir_y;
    logic [IDX_W-1:0]     k;
    logic [IDX_W-1:0]     load_ptr;
    logic                 pend_clear;
    logic                 pend_load;
    logic [X_BITS-1:0]    ld_x;
    logic [Y_BITS-1:0]    ld_y;
    logic [A_W-1:0]       clr_addr;
    logic                 von_d;
    logic                 bon_d;

    logic [COLOR_W-1:0]   vram [0:(1<<A_W)-1];
    logic [COLOR_W-1:0]   dout;
    logic                 we;
    logic [A_W-1:0]       waddr;
    logic [COLOR_W-1:0]   wdata;

    logic [COLOR_W-1:0]   col [N_DOTS];
    logic [X_BITS-1:0]    cur_x;
    logic [Y_BITS-1:0]    cur_y;
    logic                 ndir_x;
    logic                 ndir_y;
    logic [X_BITS-1:0]    nx;
    logic [Y_BITS-1:0]    ny;
    logic                 refr_tick;
    logic                 bitmap_on;

    assign refr_tick = (pix_y == 10'(REFR_Y)) && (pix_x == 10'd0);
    assign bitmap_on = ((pix_x >> X_BITS) == '0) && ((pix_y >> Y_BITS) == '0);

    always_comb begin
        for (int i = 0; i < N_DOTS; i++) begin
            col[i] = dot_color[i*COLOR_W +: COLOR_W];
        end
    end

    // Next step of dot k: the bounce decision is made first and the move
    // uses the freshly decided direction.
    always_comb begin
        cur_x  = dot_x[k];
        cur_y  = dot_y[k];
        ndir_x = (cur_x <= X_BITS'(1)) ? 1'b1 : (cur_x >= X_HI) ? 1'b0 : dir_x[k];
        ndir_y = (cur_y <= Y_BITS'(1)) ? 1'b1 : (cur_y >= Y_HI) ? 1'b0 : dir_y[k];
        nx     = ndir_x ? cur_x + X_BITS'(1) : cur_x - X_BITS'(1);
        ny     = ndir_y ? cur_y + Y_BITS'(1) : cur_y - Y_BITS'(1);
    end

    always_comb begin
        we    = 1'b0;
        waddr = clr_addr;
        wdata = '0;
        case (state)
            S_CLEAR: we = 1'b1;
            S_LOAD: begin
                we    = 1'b1;
                waddr = {ld_y, ld_x};
                wdata = col[load_ptr];
            end
            S_ERASE: begin
                we    = ~trail_en;
                waddr = {cur_y, cur_x};
            end
            S_DRAW: begin
                we    = 1'b1;
                waddr = {ny, nx};
                wdata = col[k];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            vram[waddr] <= wdata;
        end
        dout <= vram[{pix_y[Y_BITS-1:0], pix_x[X_BITS-1:0]}];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_CLEAR;
            busy       <= 1'b1;
            clr_addr   <= '0;
            k          <= '0;
            load_ptr   <= '0;
            pend_clear <= 1'b0;
            pend_load  <= 1'b0;
            ld_x       <= '0;
            ld_y       <= '0;
            von_d      <= 1'b0;
            bon_d      <= 1'b0;
            dir_x      <= '1;
            dir_y      <= '1;
            for (int i = 0; i < N_DOTS; i++) begin
                dot_x[i] <= X_BITS'(1 + 4*i);
                dot_y[i] <= Y_BITS'(1 + 4*i);
            end
        end else begin
            von_d <= video_on;
            bon_d <= bitmap_on;

            // Requests are latched in every state; the IDLE branch below
            // overrides the flag it consumes in the same cycle.
            if (load) begin
                ld_x      <= pix_x[X_BITS-1:0];
                ld_y      <= pix_y[Y_BITS-1:0];
                pend_load <= 1'b1;
            end
            if (clear && state != S_CLEAR) begin
                pend_clear <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (pend_clear || clear) begin
                        state      <= S_CLEAR;
                        clr_addr   <= '0;
                        pend_clear <= 1'b0;
                        busy       <= 1'b1;
                    end else if (pend_load || load) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end else if (refr_tick) begin
                        state <= S_ERASE;
                        k     <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (&clr_addr) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    dot_x[load_ptr] <= ld_x;
                    dot_y[load_ptr] <= ld_y;
                    load_ptr        <= (load_ptr == LAST) ? '0 : load_ptr + 1'b1;
                    if (!load) begin
                        pend_load <= 1'b0;
                    end
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_ERASE: begin
                    state <= S_DRAW;
                end
                S_DRAW: begin
                    dot_x[k] <= nx;
                    dot_y[k] <= ny;
                    dir_x[k] <= ndir_x;
                    dir_y[k] <= ndir_y;
                    if (k == LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        k     <= k + 1'b1;
                        state <= S_ERASE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        if (!von_d) begin
            bit_rgb = '0;
        end else if (bon_d) begin
            bit_rgb = dout;
        end else begin
            bit_rgb = BG_RGB;
        end
    end

endmodule

// File: tb/tb_bitmap_sprite_gen.sv
// tb/tb_bitmap_sprite_gen.sv - self-checking bench for bitmap_sprite_gen
module tb_bitmap_sprite_gen;

    logic       clk = 1'b0;
    logic       reset;
    always #5 clk = ~clk;

    logic       video_on, load, clear, trail_en, busy;
    logic [9:0] pix_x, pix_y;
    logic [5:0] dot_color;
    logic [2:0] bit_rgb;

    logic       s_video_on, s_load, s_clear, s_trail_en, s_busy;
    logic [9:0] s_pix_x, s_pix_y;
    logic [8:0] s_dot_color;
    logic [2:0] s_bit_rgb;

    bitmap_sprite_gen dut (
        .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .load(load), .clear(clear), .trail_en(trail_en), .dot_color(dot_color),
        .busy(busy), .bit_rgb(bit_rgb)
    );

    bitmap_sprite_gen #(.X_BITS(4), .Y_BITS(4), .N_DOTS(3)) dut_s (
        .clk(clk), .reset(reset), .video_on(s_video_on), .pix_x(s_pix_x), .pix_y(s_pix_y),
        .load(s_load), .clear(s_clear), .trail_en(s_trail_en), .dot_color(s_dot_color),
        .busy(s_busy), .bit_rgb(s_bit_rgb)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: picture as a flat array, dots as integer positions/directions.
    int ram [16384];
    int mx [2];
    int my [2];
    int mdx [2];
    int mdy [2];
    int ox [2];
    int oy [2];
    int lp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int color_of(input int d);
        return int'(dot_color >> (3*d)) & 7;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16384; i++) ram[i] = 0;
    endtask

    task automatic m_step(inout int p, inout int d);
        if (p <= 1) d = 1;
        else if (p >= 126) d = -1;
        p = (p + d) & 127;
    endtask

    task automatic m_tick();
        for (int d = 0; d < 2; d++) begin
            ox[d] = mx[d];
            oy[d] = my[d];
            if (!trail_en) ram[my[d]*128 + mx[d]] = 0;
            m_step(mx[d], mdx[d]);
            m_step(my[d], mdy[d]);
            ram[my[d]*128 + mx[d]] = color_of(d);
        end
    endtask

    task automatic m_load(input int x, input int y);
        mx[lp] = x;
        my[lp] = y;
        ram[y*128 + x] = color_of(lp);
        lp = (lp + 1) % 2;
    endtask

    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 20000) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic read_px(input int x, input int y, input logic von, output logic [2:0] v);
        @(negedge clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        video_on = von;
        @(negedge clk);
        v = bit_rgb;
        pix_x = 10'd0;
        pix_y = 10'd0;
    endtask

    task automatic check_px(input string tag, input int x, input int y);
        logic [2:0] v;
        read_px(x, y, 1'b1, v);
        check(tag, v, ram[y*128 + x]);
    endtask

    task automatic check_scene(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_px({tag, "_new"}, mx[d], my[d]);
            check_px({tag, "_old"}, ox[d], oy[d]);
        end
        for (int i = 0; i < 4; i++) begin
            check_px({tag, "_rand"}, $urandom_range(0, 127), $urandom_range(0, 127));
        end
    endtask

    task automatic do_tick(input string tag);
        int cnt;
        @(negedge clk);
        pix_x = 10'd0;
        pix_y = 10'd481;
        @(negedge clk);
        pix_y = 10'd0;
        m_tick();
        wait_busy(cnt);
        check({tag, "_frame_cycles"}, cnt, 4);
        check_scene(tag);
    endtask

    task automatic do_load(input string tag, input int x, input int y);
        int cnt;
        @(negedge clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        pix_x = 10'd0;
        pix_y = 10'd0;
        m_load(x, y);
        wait_busy(cnt);
        check({tag, "_load_cycles"}, cnt, 1);
        check_px({tag, "_load_px"}, x, y);
    endtask

    initial begin
        int c0, c1, cnt;
        logic [2:0] v;
        int tq [$];

        reset = 1'b1;
        video_on = 1'b0; pix_x = '0; pix_y = '0; load = 1'b0; clear = 1'b0;
        trail_en = 1'b0; dot_color = {3'b101, 3'b011};
        s_video_on = 1'b0; s_pix_x = '0; s_pix_y = '0; s_load = 1'b0; s_clear = 1'b0;
        s_trail_en = 1'b0; s_dot_color = {3'b111, 3'b010, 3'b100};
        for (int d = 0; d < 2; d++) begin
            mx[d] = 1 + 4*d; my[d] = 1 + 4*d; mdx[d] = 1; mdy[d] = 1;
            ox[d] = mx[d]; oy[d] = my[d];
        end
        lp = 0;

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1);
        check("reset_rgb", bit_rgb, 0);
        check("reset_busy_small", s_busy, 1);

        // Clear after reset: count clocks with busy high on both instances.
        reset = 1'b0;
        c0 = 0;
        c1 = 0;
        for (int t = 0; t < 20000 && (busy === 1'b1 || s_busy === 1'b1); t++) begin
            if (busy === 1'b1) c0++;
            if (s_busy === 1'b1) c1++;
            @(negedge clk);
        end
        check("clear_cycles", c0, 16384);
        check("clear_cycles_small", c1, 256);
        m_clear();

        // Pipelined full scan of the cleared bitmap.
        video_on = 1'b1;
        for (int i = 0; i <= 16384; i++) begin
            @(negedge clk);
            if (i > 0) check("scan", bit_rgb, ram[i-1]);
            if (i < 16384) begin
                pix_x = 10'(i % 128);
                pix_y = 10'(i / 128);
            end
        end
        read_px(200, 50, 1'b1, v);
        check("bg_outside", v, 3'b110);
        read_px(200, 50, 1'b0, v);
        check("blank_outside", v, 0);
        read_px(5, 5, 1'b0, v);
        check("blank_inside", v, 0);

        // Plain movement, then bounce at the right edge, then load at origin.
        do_tick("move");
        do_load("ld126", 126, 10);
        for (int i = 0; i < 3; i++) do_tick("bounce");
        do_load("ld00", 0, 0);
        do_tick("from_origin");

        // Trails: every drawn position stays coloured.
        trail_en = 1'b1;
        tq.delete();
        for (int i = 0; i < 3; i++) begin
            do_tick("trail");
            for (int d = 0; d < 2; d++) tq.push_back(my[d]*128 + mx[d]);
        end
        foreach (tq[i]) check_px("trail_kept", tq[i] % 128, tq[i] / 128);
        trail_en = 1'b0;

        // Clear and load requested mid-update; a tick during CLEAR is dropped.
        @(negedge clk);
        pix_x = 10'd0;
        pix_y = 10'd481;
        @(negedge clk);
        pix_x = 10'd40;
        pix_y = 10'd30;
        clear = 1'b1;
        load = 1'b1;
        check("upd_busy", busy, 1);
        @(negedge clk);
        clear = 1'b0;
        load = 1'b0;
        pix_x = 10'd0;
        pix_y = 10'd0;
        m_tick();
        wait_busy(cnt);
        check("upd_rest_cycles", cnt, 3);
        @(negedge clk);
        check("clear_start", busy, 1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 20000) begin
            pix_x = 10'd0;
            pix_y = (cnt == 100) ? 10'd481 : 10'd0;
            @(negedge clk);
            cnt++;
        end
        pix_y = 10'd0;
        check("pend_clear_cycles", cnt, 16384);
        @(negedge clk);
        check("pend_load_start", busy, 1);
        wait_busy(cnt);
        check("pend_load_cycles", cnt, 1);
        m_clear();
        m_load(40, 30);
        check_px("pend_load_px", 40, 30);
        for (int d = 0; d < 2; d++) begin
            ox[d] = mx[d];
            oy[d] = my[d];
        end
        check_scene("after_clear");
        do_tick("after_clear_tick");

        // Randomised mix of ticks and loads with random colours and trail mode.
        for (int i = 0; i < 8; i++) begin
            dot_color = 6'($urandom);
            trail_en = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                for (int d = 0; d < 2; d++) begin
                    ox[d] = mx[d];
                    oy[d] = my[d];
                end
                do_load("rnd_ld", $urandom_range(0, 127), $urandom_range(0, 127));
            end else begin
                do_tick("rnd_tick");
            end
        end

        // Small instance: 6-cycle frame, dots (1,1),(5,5),(9,9) step diagonally.
        @(negedge clk);
        s_pix_x = 10'd0;
        s_pix_y = 10'd481;
        @(negedge clk);
        s_pix_y = 10'd0;
        cnt = 0;
        while (s_busy === 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("small_frame_cycles", cnt, 6);
        s_video_on = 1'b1;
        for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            s_pix_x = 10'(2 + 4*d);
            s_pix_y = 10'(2 + 4*d);
            @(negedge clk);
            check("small_dot", s_bit_rgb, int'(s_dot_color >> (3*d)) & 7);
            s_pix_x = 10'(1 + 4*d);
            s_pix_y = 10'(1 + 4*d);
            @(negedge clk);
            check("small_erased", s_bit_rgb, 0);
        end
        s_pix_x = 10'd16;
        s_pix_y = 10'd3;
        @(negedge clk);
        check("small_bg", s_bit_rgb, 3'b110);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
